// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch front end.
//   - fetch_state_t : in-flight status of the instruction-memory port
//   - ifid_word_t   : one IF/ID payload (instruction + PC+4); used by both the
//                     IF/ID register and the one-entry skid buffer
//   - NOP           : instruction word placed in IF/ID when it holds a bubble
//   - pc_next       : sequential PC increment, modulo 2**32
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // nothing outstanding
    S_WAIT  = 2'd1,  // one request outstanding, its response will be kept
    S_DRAIN = 2'd2   // one request outstanding, its response will be discarded
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_word_t;

  // 32'hFFFF_FFFC + 4 wraps to 0 by truncation to 32 bits.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
//   One-entry holding register for an IF/ID payload. Catches an instruction
//   response that arrives while IF/ID is stalled so the response is never
//   lost and the memory port does not need to be re-requested.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (empties the entry)
//   load   in   capture din; entry becomes valid
//   clear  in   empty the entry (wins over load)
//   din    in   payload to capture
//   valid  out  entry holds a payload
//   dout   out  held payload (meaningful only while valid=1)
// ---------------------------------------------------------------------------
module fetch_skid
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  ifid_word_t din,
  output logic       valid,
  output ifid_word_t dout
);

  // Occupancy flag is control and is reset; clear has priority so a redirect
  // in the same cycle as a capture still leaves the entry empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
//   Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the PC and
//   the IF/ID register, drives a request/response instruction-memory port
//   with at most one request in flight, and parks a response that arrives
//   during an IF/ID stall in a one-entry skid buffer.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   CNT_W     width of the saturating starvation counter
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   pc_write     in   1 = a new fetch may be issued; 0 = hold PC, issue nothing
//   if_id_write  in   1 = IF/ID may load; 0 = IF/ID holds
//   redirect     in   branch taken / jump in ID: flush and refetch
//   redirect_pc  in   redirect target, sampled while redirect=1
//   imem_req     out  fetch request, one-cycle pulse
//   imem_addr    out  fetch address, valid while imem_req=1
//   imem_ready   in   response strobe, exactly one per request
//   imem_rdata   in   instruction, valid while imem_ready=1
//   if_id_instr  out  IF/ID instruction (NOP when invalid)
//   if_id_pc4    out  IF/ID PC+4 of that instruction
//   if_id_valid  out  IF/ID holds a real instruction
//   starve_cnt   out  bubbles inserted for lack of fetch data (saturating)
// ---------------------------------------------------------------------------
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] starve_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc4;

  logic         resp_take;
  ifid_word_t   resp_word;

  logic         skid_valid;
  logic         skid_load;
  logic         skid_clear;
  ifid_word_t   skid_word;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pc4 = pc_next(pc);

  // A response is kept only when it belongs to a live request and no
  // redirect is flushing the front end in the same cycle.
  assign resp_take = (state == S_WAIT) && imem_ready && !redirect;
  assign resp_word = '{instr: imem_rdata, pc4: pc4};

  // -------------------------------------------------------------------------
  // Request generation (combinational so a zero-wait memory can be fed one
  // request per cycle)
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (!rst && !redirect) begin
      case (state)
        // An occupied skid means IF/ID already has work queued; fetching
        // more would risk a second response with nowhere to go.
        S_IDLE: imem_req = pc_write && !skid_valid;
        // Back-to-back issue only when the current response goes straight
        // into IF/ID; the next address is the one after the response.
        S_WAIT: begin
          if (imem_ready && if_id_write && pc_write && !skid_valid) begin
            imem_req  = 1'b1;
            imem_addr = pc4;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Fetch-port FSM and PC
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (resp_take) begin
        pc <= pc4;
      end

      case (state)
        S_IDLE: begin
          if (imem_req) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // With ready, imem_req already encodes back-to-back issue (and is
          // forced low by redirect, which drops the response).
          if (imem_ready) begin
            state <= imem_req ? S_WAIT : S_IDLE;
          end else if (redirect) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The discarded response retires the old request; a redirect here
          // only updates the PC, which already happened above.
          if (imem_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Skid buffer: captures a kept response while IF/ID is stalled
  // -------------------------------------------------------------------------
  assign skid_load  = resp_take && !if_id_write;
  assign skid_clear = redirect || (if_id_write && skid_valid);

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (resp_word),
    .valid (skid_valid),
    .dout  (skid_word)
  );

  // -------------------------------------------------------------------------
  // IF/ID register and starvation counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc4   <= 32'h0;
      starve_cnt  <= '0;
    end else if (redirect) begin
      // Flush overrides a stall: the instruction in IF/ID is on the wrong path.
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
    end else if (if_id_write) begin
      if (skid_valid) begin
        if_id_valid <= 1'b1;
        if_id_instr <= skid_word.instr;
        if_id_pc4   <= skid_word.pc4;
      end else if (resp_take) begin
        if_id_valid <= 1'b1;
        if_id_instr <= resp_word.instr;
        if_id_pc4   <= resp_word.pc4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP;
        starve_cnt  <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_ctrl
//   Directed bench for fetch_stage_ctrl. A small instruction-memory responder
//   (inside tick) answers each request after `lat` cycles with
//   rdata = addr | 32'hA000_0000. Each scenario task checks hand-computed
//   values inline. The DUT is built with CNT_W=2 so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [1:0]  starve_cnt;

  int checks = 0;
  int errors = 0;

  // responder state
  int          lat;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .starve_cnt  (starve_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  // Advance one clock. The request seen just before the edge is recorded;
  // its response is presented `lat` cycles later for exactly one cycle.
  task automatic tick();
    #1;
    if (imem_req === 1'b1) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
    end
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = pend_addr | 32'hA000_0000;
        pend       = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    pc_write = 1'b1; if_id_write = 1'b1;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    pend = 1'b0; pend_cnt = 0; lat = 1;
    tick();
    tick();
    rst = 1'b0; pend = 1'b0; imem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    pc_write = 1'b1; if_id_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, if_id_valid); end
      checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr cyc%0d got %h exp 0", i, if_id_instr); end
      checks++; if (starve_cnt !== 2'd0) begin errors++; $display("FAIL reset_starve cyc%0d got %0d exp 0", i, starve_cnt); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req cyc%0d got %b exp 0", i, imem_req); end
    end
    rst = 1'b0; imem_ready = 1'b0; pend = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_addr got %h exp 0", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid got %b exp 0", if_id_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_c0_req got %b/%h exp 1/0", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stream_c1_req got %b/%h exp 1/4", imem_req, imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %b exp 0", if_id_valid); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0000 || if_id_pc4 !== 32'h4) begin errors++; $display("FAIL stream_c2_ifid got %b/%h/%h exp 1/a0000000/4", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stream_c2_req got %b/%h exp 1/8", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0004 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL stream_c3_ifid got %b/%h/%h exp 1/a0000004/8", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stream_c3_req got %b/%h exp 1/c", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0008 || if_id_pc4 !== 32'hC) begin errors++; $display("FAIL stream_c4_ifid got %b/%h/%h exp 1/a0000008/c", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_c4_req got %b exp 1", imem_req); end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick(); tick(); tick();
    // response for addr 8 is present now; stall everything
    pc_write = 1'b0; if_id_write = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0004 || if_id_pc4 !== 32'h8) begin errors++; $display("FAIL stall_hold got %b/%h/%h exp 1/a0000004/8", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (dut.skid_valid !== 1'b1 || dut.skid_word.instr !== 32'hA000_0008 || dut.skid_word.pc4 !== 32'hC) begin errors++; $display("FAIL stall_skid got %b/%h/%h exp 1/a0000008/c", dut.skid_valid, dut.skid_word.instr, dut.skid_word.pc4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_held got %b exp 0", imem_req); end
    pc_write = 1'b1; if_id_write = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL release_req_skidfull got %b exp 0", imem_req); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0008 || if_id_pc4 !== 32'hC) begin errors++; $display("FAIL release_ifid got %b/%h/%h exp 1/a0000008/c", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL release_next_req got %b/%h exp 1/c", imem_req, imem_addr); end
    checks++; if (dut.skid_valid !== 1'b0) begin errors++; $display("FAIL release_skid_empty got %b exp 0", dut.skid_valid); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    tick(); tick(); tick(); tick();
    lat = 3;  // request for 0x10 is issued in this cycle
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drain_req10 got %b/%h exp 1/10", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_000C || if_id_pc4 !== 32'h10) begin errors++; $display("FAIL drain_ifid_c got %b/%h/%h exp 1/a000000c/10", if_id_valid, if_id_instr, if_id_pc4); end
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_redirect_req got %b exp 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL drain_flush got %b/%h exp 0/0", if_id_valid, if_id_instr); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_wait_req got %b exp 0", imem_req); end
    tick();
    checks++; if (imem_ready !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL drain_ready_req got ready %b req %b exp 1/0", imem_ready, imem_req); end
    tick();
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL drain_dropped got %b/%h exp 0/0", if_id_valid, if_id_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL drain_refetch got %b/%h exp 1/40", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    tick(); tick(); tick(); tick();
    lat = 3;
    tick(); tick(); tick();
    checks++; if (imem_ready !== 1'b1) begin errors++; $display("FAIL same_ready_setup got %b exp 1", imem_ready); end
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL same_req got %b exp 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL same_dropped got %b/%h exp 0/0", if_id_valid, if_id_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL same_refetch got %b/%h exp 1/40", imem_req, imem_addr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle_redirect_req got %b exp 0", imem_req); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %b/%h exp 1/0", imem_req, imem_addr); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_ifid got %b/%h/%h exp 1/fffffffc/0", if_id_valid, if_id_instr, if_id_pc4); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_after got %b/%h exp 1/4", imem_req, imem_addr); end
  endtask

  task automatic test_starve();
    do_reset();
    lat = 3;
    checks++; if (starve_cnt !== 2'd0) begin errors++; $display("FAIL starve_c0 got %0d exp 0", starve_cnt); end
    tick();
    checks++; if (starve_cnt !== 2'd1) begin errors++; $display("FAIL starve_c1 got %0d exp 1", starve_cnt); end
    if_id_write = 1'b0;
    tick();
    checks++; if (starve_cnt !== 2'd1) begin errors++; $display("FAIL starve_stalled got %0d exp 1", starve_cnt); end
    if_id_write = 1'b1;
    tick();
    checks++; if (starve_cnt !== 2'd2) begin errors++; $display("FAIL starve_c3 got %0d exp 2", starve_cnt); end
    tick();
    checks++; if (starve_cnt !== 2'd2 || if_id_instr !== 32'hA000_0000) begin errors++; $display("FAIL starve_load got %0d/%h exp 2/a0000000", starve_cnt, if_id_instr); end
    tick();
    checks++; if (starve_cnt !== 2'd3) begin errors++; $display("FAIL starve_c5 got %0d exp 3", starve_cnt); end
    tick();
    checks++; if (starve_cnt !== 2'd3) begin errors++; $display("FAIL starve_sat got %0d exp 3", starve_cnt); end
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b0; if_id_write = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    lat = 1; pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_pc_wrap();
    test_starve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
